dmem_arbiter: RTL and testbench

- Shares one single-port, byte-writable, synchronous data memory between two requesters.
- Port 0 (D) is the MEM-stage load/store path; port 1 (F) is the instruction fetch path.
- Fixed priority with a starvation guard. Response routing is aligned to the memory's 1-cycle read latency.
- A non-granted requester stalls its pipeline stage until granted.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: groups the D requester, F requester and memory-side
// signals of the data-memory arbiter. Signal suffixes are from the
// arbiter's point of view: the slave modport is the arbiter, and the master
// modport is the surrounding environment (requesters plus memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // D (MEM-stage load/store) port
    logic              d_req_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic              d_read_i;
    logic [3:0]        d_wsel_byte_i;
    logic [31:0]       d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;

    // F (instruction fetch) port
    logic              f_req_i;
    logic [ADDR_W-1:0] f_addr_i;
    logic              f_gnt_o;
    logic              f_rvalid_o;
    logic [31:0]       f_rdata_o;

    // Memory side
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_read_o;
    logic [3:0]        mem_wsel_byte_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  d_req_i, d_addr_i, d_read_i, d_wsel_byte_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        input  f_req_i, f_addr_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o,
        input  mem_ready_i, mem_rdata_i,
        output mem_addr_o, mem_read_o, mem_wsel_byte_o, mem_wdata_o
    );

    modport master (
        output d_req_i, d_addr_i, d_read_i, d_wsel_byte_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        output f_req_i, f_addr_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o,
        output mem_ready_i, mem_rdata_i,
        input  mem_addr_o, mem_read_o, mem_wsel_byte_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, byte-writable, 1-cycle-latency data
// memory between the D (load/store) and F (fetch) requesters.
// Default build: D has fixed priority, with a starvation counter that hands
// F one arbitration after STARVE_LIMIT consecutive denied cycles
// (STARVE_LIMIT = 0 disables the guard).
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration instead; in that
// build STARVE_LIMIT is ignored.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    dmem_arbiter_if.slave  bus
);

    logic win_d;
    logic win_f;
    logic d_gnt;
    logic f_gnt;
    logic resp_d_q, resp_d_d;
    logic resp_f_q, resp_f_d;

`ifdef DMEM_ARB_RR_EN
    // last_f_q: 1 when the most recent grant went to F.
    // rr_seen_q: 0 until the first grant after reset, so D wins the very
    // first contention and grants then alternate D, F, D, F.
    logic last_f_q, last_f_d;
    logic rr_seen_q, rr_seen_d;

    // Round-robin winner: a lone requester always wins; on contention the
    // port that was not granted last wins.
    always_comb begin
        win_d = bus.d_req_i & (~bus.f_req_i | last_f_q | ~rr_seen_q);
        win_f = bus.f_req_i & ~win_d;
    end

    // Remember which port received the last grant.
    always_comb begin
        last_f_d  = last_f_q;
        rr_seen_d = rr_seen_q;
        if (d_gnt) begin
            last_f_d  = 1'b0;
            rr_seen_d = 1'b1;
        end else if (f_gnt) begin
            last_f_d  = 1'b1;
            rr_seen_d = 1'b1;
        end
    end

    // Round-robin history registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_f_q  <= 1'b0;
            rr_seen_q <= 1'b0;
        end else begin
            last_f_q  <= last_f_d;
            rr_seen_q <= rr_seen_d;
        end
    end
`else
    // Counter is at least 1 bit wide so STARVE_LIMIT = 0 still elaborates.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_f;

    // Fixed D priority, except when F has been starved long enough.
    always_comb begin
        force_f = (STARVE_LIMIT != 0) && (starve_cnt_q == LIMIT_C);
        win_d   = bus.d_req_i & ~(force_f & bus.f_req_i);
        win_f   = bus.f_req_i & ~win_d;
    end

    // Count cycles F was denied while memory was ready; a stalled memory
    // freezes the count, and a grant or withdrawn request clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.f_req_i || f_gnt) begin
            starve_cnt_d = '0;
        end else if (bus.mem_ready_i && (starve_cnt_q != LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Grants are only issued when the memory can accept the access.
    always_comb begin
        d_gnt       = win_d & bus.mem_ready_i;
        f_gnt       = win_f & bus.mem_ready_i;
        bus.d_gnt_o = d_gnt;
        bus.f_gnt_o = f_gnt;
    end

    // Steer the granted requester onto the memory bus; idle bus is all zero.
    // A D read never writes, even if the requester left byte lanes set.
    always_comb begin
        bus.mem_addr_o      = {ADDR_W{1'b0}};
        bus.mem_read_o      = 1'b0;
        bus.mem_wsel_byte_o = 4'b0000;
        bus.mem_wdata_o     = 32'h0;
        if (d_gnt) begin
            bus.mem_addr_o = bus.d_addr_i;
            bus.mem_read_o = bus.d_read_i;
            if (!bus.d_read_i) begin
                bus.mem_wsel_byte_o = bus.d_wsel_byte_i;
                bus.mem_wdata_o     = bus.d_wdata_i;
            end
        end else if (f_gnt) begin
            bus.mem_addr_o = bus.f_addr_i;
            bus.mem_read_o = 1'b1;
        end
    end

    // A granted read owes its port a response in the following cycle.
    always_comb begin
        resp_d_d = d_gnt & bus.d_read_i;
        resp_f_d = f_gnt;
    end

    // Response-routing flags, aligned with the memory's 1-cycle read latency.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_d_q <= 1'b0;
            resp_f_q <= 1'b0;
        end else begin
            resp_d_q <= resp_d_d;
            resp_f_q <= resp_f_d;
        end
    end

    // Deliver read data only to the port that owns this cycle's response.
    always_comb begin
        bus.d_rvalid_o = resp_d_q;
        bus.f_rvalid_o = resp_f_q;
        bus.d_rdata_o  = resp_d_q ? bus.mem_rdata_i : 32'h0;
        bus.f_rdata_o  = resp_f_q ? bus.mem_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter in its default build
// (fixed D priority, STARVE_LIMIT = 4).
module tb_dmem_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W(32)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.d_req_i       = 1'b0;
        bus.d_addr_i      = 32'h0;
        bus.d_read_i      = 1'b0;
        bus.d_wsel_byte_i = 4'h0;
        bus.d_wdata_i     = 32'h0;
        bus.f_req_i       = 1'b0;
        bus.f_addr_i      = 32'h0;
        bus.mem_ready_i   = 1'b1;
        bus.mem_rdata_i   = 32'h0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dgnt"},   64'(bus.d_gnt_o),         64'h0);
        chk({tag, "_fgnt"},   64'(bus.f_gnt_o),         64'h0);
        chk({tag, "_mread"},  64'(bus.mem_read_o),      64'h0);
        chk({tag, "_maddr"},  64'(bus.mem_addr_o),      64'h0);
        chk({tag, "_mwsel"},  64'(bus.mem_wsel_byte_o), 64'h0);
        chk({tag, "_mwdata"}, 64'(bus.mem_wdata_o),     64'h0);
        chk({tag, "_drv"},    64'(bus.d_rvalid_o),      64'h0);
        chk({tag, "_frv"},    64'(bus.f_rvalid_o),      64'h0);
        chk({tag, "_drd"},    64'(bus.d_rdata_o),       64'h0);
        chk({tag, "_frd"},    64'(bus.f_rdata_o),       64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        idle_inputs();
        bus.mem_rdata_i = 32'hFFFF_FFFF;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_drv", 64'(bus.d_rvalid_o), 64'h0);
        chk("rst_drd", 64'(bus.d_rdata_o),  64'h0);
        chk("rst_frd", 64'(bus.f_rdata_o),  64'h0);
        bus.mem_rdata_i = 32'h0;
        #1;
        chk_idle("rst");
        rstn = 1'b1;
        tick();

        // D read 0x100 alone; stray byte lanes must not reach memory
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h100; bus.d_read_i = 1'b1;
        bus.d_wsel_byte_i = 4'hF;
        @(negedge clk);
        chk("rd_dgnt",  64'(bus.d_gnt_o),         64'h1);
        chk("rd_fgnt",  64'(bus.f_gnt_o),         64'h0);
        chk("rd_mread", 64'(bus.mem_read_o),      64'h1);
        chk("rd_maddr", 64'(bus.mem_addr_o),      64'h100);
        chk("rd_mwsel", 64'(bus.mem_wsel_byte_o), 64'h0);
        chk("rd_drv0",  64'(bus.d_rvalid_o),      64'h0);
        tick();
        idle_inputs();
        bus.mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_drv1",  64'(bus.d_rvalid_o), 64'h1);
        chk("rd_drd1",  64'(bus.d_rdata_o),  64'hDEADBEEF);
        chk("rd_frv1",  64'(bus.f_rvalid_o), 64'h0);
        chk("rd_frd1",  64'(bus.f_rdata_o),  64'h0);
        chk("rd_mread1", 64'(bus.mem_read_o), 64'h0);
        tick();
        @(negedge clk);
        chk("rd_drv2", 64'(bus.d_rvalid_o), 64'h0);
        chk("rd_drd2", 64'(bus.d_rdata_o),  64'h0);

        // D write 0x104, lane 2
        tick();
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h104; bus.d_read_i = 1'b0;
        bus.d_wsel_byte_i = 4'b0100; bus.d_wdata_i = 32'h00AB0000;
        @(negedge clk);
        chk("wr_dgnt",   64'(bus.d_gnt_o),         64'h1);
        chk("wr_mread",  64'(bus.mem_read_o),      64'h0);
        chk("wr_maddr",  64'(bus.mem_addr_o),      64'h104);
        chk("wr_mwsel",  64'(bus.mem_wsel_byte_o), 64'h4);
        chk("wr_mwdata", 64'(bus.mem_wdata_o),     64'h00AB0000);
        tick();
        idle_inputs();
        bus.mem_rdata_i = 32'h12345678;
        @(negedge clk);
        chk("wr_drv", 64'(bus.d_rvalid_o), 64'h0);
        chk("wr_frv", 64'(bus.f_rvalid_o), 64'h0);
        tick();

        // Continuous contention: D,D,D,D,F repeating
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h200; bus.d_read_i = 1'b1;
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h40;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            logic prev_f;
            exp_f  = ((i % 5) == 4);
            prev_f = (i > 0) && (((i - 1) % 5) == 4);
            bus.mem_rdata_i = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            chk($sformatf("arb_dgnt%0d", i), 64'(bus.d_gnt_o), 64'(!exp_f));
            chk($sformatf("arb_fgnt%0d", i), 64'(bus.f_gnt_o), 64'(exp_f));
            chk($sformatf("arb_maddr%0d", i), 64'(bus.mem_addr_o),
                exp_f ? 64'h40 : 64'h200);
            chk($sformatf("arb_drv%0d", i), 64'(bus.d_rvalid_o), 64'((i > 0) && !prev_f));
            chk($sformatf("arb_frv%0d", i), 64'(bus.f_rvalid_o), 64'(prev_f));
            tick();
        end
        idle_inputs();
        tick();

        // F granted, then D granted the next cycle
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h44;
        @(negedge clk);
        chk("fd_fgnt",  64'(bus.f_gnt_o),         64'h1);
        chk("fd_mread", 64'(bus.mem_read_o),      64'h1);
        chk("fd_mwsel", 64'(bus.mem_wsel_byte_o), 64'h0);
        chk("fd_maddr", 64'(bus.mem_addr_o),      64'h44);
        tick();
        bus.f_req_i = 1'b0;
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h108; bus.d_read_i = 1'b1;
        bus.mem_rdata_i = 32'h11111111;
        @(negedge clk);
        chk("fd_frv1", 64'(bus.f_rvalid_o), 64'h1);
        chk("fd_frd1", 64'(bus.f_rdata_o),  64'h11111111);
        chk("fd_drv1", 64'(bus.d_rvalid_o), 64'h0);
        chk("fd_drd1", 64'(bus.d_rdata_o),  64'h0);
        chk("fd_dgnt1", 64'(bus.d_gnt_o),   64'h1);
        tick();
        idle_inputs();
        bus.mem_rdata_i = 32'h22222222;
        @(negedge clk);
        chk("fd_drv2", 64'(bus.d_rvalid_o), 64'h1);
        chk("fd_drd2", 64'(bus.d_rdata_o),  64'h22222222);
        chk("fd_frv2", 64'(bus.f_rvalid_o), 64'h0);
        chk("fd_frd2", 64'(bus.f_rdata_o),  64'h0);
        tick();

        // Memory stall freezes the starvation count
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h300; bus.d_read_i = 1'b1;
        bus.f_req_i = 1'b1; bus.f_addr_i = 32'h80;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("st_pre_dgnt%0d", i), 64'(bus.d_gnt_o), 64'h1);
            tick();
        end
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("st_dgnt%0d", i),  64'(bus.d_gnt_o),    64'h0);
            chk($sformatf("st_fgnt%0d", i),  64'(bus.f_gnt_o),    64'h0);
            chk($sformatf("st_mread%0d", i), 64'(bus.mem_read_o), 64'h0);
            chk($sformatf("st_maddr%0d", i), 64'(bus.mem_addr_o), 64'h0);
            chk($sformatf("st_drv%0d", i),   64'(bus.d_rvalid_o), 64'(i == 0));
            chk($sformatf("st_drd%0d", i),   64'(bus.d_rdata_o),
                (i == 0) ? 64'h5555AAAA : 64'h0);
            tick();
        end
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("st_post_dgnt%0d", i), 64'(bus.d_gnt_o), 64'(i != 2));
            chk($sformatf("st_post_fgnt%0d", i), 64'(bus.f_gnt_o), 64'(i == 2));
            tick();
        end
        idle_inputs();
        tick();

        // Reset the cycle after a granted read discards the response
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h10C; bus.d_read_i = 1'b1;
        @(negedge clk);
        chk("rr_dgnt", 64'(bus.d_gnt_o), 64'h1);
        tick();
        rstn = 1'b0;
        idle_inputs();
        bus.mem_rdata_i = 32'hCAFEF00D;
        #1;
        chk("rr_drv", 64'(bus.d_rvalid_o), 64'h0);
        chk("rr_drd", 64'(bus.d_rdata_o),  64'h0);
        @(negedge clk);
        chk("rr_drv_hold", 64'(bus.d_rvalid_o), 64'h0);
        tick();
        rstn = 1'b1;
        tick();
        @(negedge clk);
        chk_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
